// File: rtl/match_req_issuer.sv
// match_req_issuer: fans one match job out as per-candidate requests over
// NUM_PE match PEs and reduces the tagged responses to the best candidate.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef MATCH_LEN_WIDTH
`define MATCH_LEN_WIDTH 6
`endif

module match_req_issuer #(
   parameter  int TAG_BITS = 8,
   parameter  int NUM_PE   = 4,
   parameter  int MAX_CAND = 8,
   localparam int CI = (MAX_CAND > 1) ? $clog2(MAX_CAND) : 1,
   localparam int AW = `ADDR_WIDTH,
   localparam int ML = `MATCH_LEN_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     job_valid,
   output logic                     job_ready,
   input  logic [AW-1:0]            job_head_addr,
   input  logic [CI:0]              job_cand_count,
   input  logic [MAX_CAND*AW-1:0]   job_cand_addr,
   output logic [NUM_PE-1:0]        match_req_valid,
   input  logic [NUM_PE-1:0]        match_req_ready,
   output logic [NUM_PE*TAG_BITS-1:0] match_req_tag,
   output logic [NUM_PE*AW-1:0]     match_req_head_addr,
   output logic [NUM_PE*AW-1:0]     match_req_history_addr,
   input  logic [NUM_PE-1:0]        match_resp_valid,
   output logic [NUM_PE-1:0]        match_resp_ready,
   input  logic [NUM_PE*TAG_BITS-1:0] match_resp_tag,
   input  logic [NUM_PE*ML-1:0]     match_resp_match_len,
   output logic                     result_valid,
   input  logic                     result_ready,
   output logic [ML-1:0]            result_match_len,
   output logic [CI-1:0]            result_cand_idx,
   output logic [AW-1:0]            result_history_addr
);

   localparam int PI = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_RESULT
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [PI-1:0]   r_rr_ptr;
   logic [AW-1:0]   r_head;
   logic [CI:0]     r_count;
   logic [AW-1:0]   r_cand [MAX_CAND];
   logic [CI:0]     r_issue_idx;
   logic [CI:0]     r_resp_cnt;
   logic [ML-1:0]   r_best_len;
   logic [CI-1:0]   r_best_idx;
   logic            r_best_seen;

   logic [CI-1:0]   w_iidx;
   logic [CI:0]     w_issue_inc;
   logic [CI:0]     w_resp_inc;
   logic [PI-1:0]   w_rr_nxt;
   logic            w_req_fire;
   logic            w_collect;
   logic            w_resp_fire;
   logic            w_resp_done;
   logic [TAG_BITS-1:0] w_rtag;
   logic [TAG_BITS-1:0] w_req_tag;
   logic [TAG_BITS:0]   w_cnt_ext;
   logic [ML-1:0]   w_rlen;
   logic [CI-1:0]   w_rtag_idx;
   logic            w_tag_ok;
   logic            w_better;

   assign w_iidx      = r_issue_idx[CI-1:0];
   assign w_issue_inc = r_issue_idx + 1'b1;
   assign w_resp_inc  = r_resp_cnt + 1'b1;
   assign w_rr_nxt    = (r_rr_ptr == PI'(NUM_PE - 1)) ? '0 : r_rr_ptr + 1'b1;
   assign w_req_fire  = (r_state == S_ISSUE) && match_req_ready[r_rr_ptr];
   assign w_collect   = (r_state == S_ISSUE) || (r_state == S_DRAIN);
   assign w_resp_done = w_resp_fire && (w_resp_inc == r_count);
   assign job_ready   = (r_state == S_IDLE);

   // one request lane at rr_ptr; all other lanes stay at zero
   always_comb begin
      match_req_valid        = '0;
      match_req_tag          = '0;
      match_req_head_addr    = '0;
      match_req_history_addr = '0;
      w_req_tag              = '0;
      w_req_tag[CI-1:0]      = w_iidx;
      if (r_state == S_ISSUE) begin
         for (int p = 0; p < NUM_PE; p++) begin
            if (r_rr_ptr == PI'(p)) begin
               match_req_valid[p]                  = 1'b1;
               match_req_tag[p*TAG_BITS +: TAG_BITS] = w_req_tag;
               match_req_head_addr[p*AW +: AW]     = r_head;
               match_req_history_addr[p*AW +: AW]  = r_cand[w_iidx];
            end
         end
      end
   end

   // fixed priority: lowest-index valid PE wins the single response slot
   always_comb begin
      match_resp_ready = '0;
      w_resp_fire      = 1'b0;
      w_rtag           = '0;
      w_rlen           = '0;
      if (w_collect) begin
         for (int p = NUM_PE - 1; p >= 0; p--) begin
            if (match_resp_valid[p]) begin
               match_resp_ready    = '0;
               match_resp_ready[p] = 1'b1;
               w_resp_fire         = 1'b1;
               w_rtag = match_resp_tag[p*TAG_BITS +: TAG_BITS];
               w_rlen = match_resp_match_len[p*ML +: ML];
            end
         end
      end
   end

   always_comb begin
      w_cnt_ext         = '0;
      w_cnt_ext[CI:0]   = r_count;
      w_rtag_idx        = w_rtag[CI-1:0];
      w_tag_ok          = ({1'b0, w_rtag} < w_cnt_ext);
      w_better          = w_tag_ok &&
                          (!r_best_seen ||
                           (w_rlen > r_best_len) ||
                           ((w_rlen == r_best_len) &&
                            (w_rtag_idx < r_best_idx)));
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (job_valid)
               w_state_nxt = (job_cand_count == '0) ? S_RESULT : S_ISSUE;
         end
         S_ISSUE: begin
            if (w_resp_done)
               w_state_nxt = S_RESULT;
            else if (w_req_fire && (w_issue_inc == r_count))
               w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (w_resp_done)
               w_state_nxt = S_RESULT;
         end
         S_RESULT: begin
            if (result_ready)
               w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_rr_ptr    <= '0;
         r_head      <= '0;
         r_count     <= '0;
         r_issue_idx <= '0;
         r_resp_cnt  <= '0;
         r_best_len  <= '0;
         r_best_idx  <= '0;
         r_best_seen <= 1'b0;
         for (int k = 0; k < MAX_CAND; k++)
            r_cand[k] <= '0;
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == S_IDLE) && job_valid) begin
            r_head      <= job_head_addr;
            r_count     <= job_cand_count;
            r_issue_idx <= '0;
            r_resp_cnt  <= '0;
            r_best_len  <= '0;
            r_best_idx  <= '0;
            r_best_seen <= 1'b0;
            // an empty job reports address 0, so keep no stale addresses
            for (int k = 0; k < MAX_CAND; k++)
               r_cand[k] <= (job_cand_count == '0) ? '0 :
                            job_cand_addr[k*AW +: AW];
         end
         if (w_req_fire) begin
            r_issue_idx <= w_issue_inc;
            r_rr_ptr    <= w_rr_nxt;
         end
         if (w_resp_fire) begin
            r_resp_cnt <= w_resp_inc;
            if (w_better) begin
               r_best_len  <= w_rlen;
               r_best_idx  <= w_rtag_idx;
               r_best_seen <= 1'b1;
            end
         end
      end
   end

   assign result_valid        = (r_state == S_RESULT);
   assign result_match_len    = result_valid ? r_best_len : '0;
   assign result_cand_idx     = result_valid ? r_best_idx : '0;
   assign result_history_addr = result_valid ? r_cand[r_best_idx] : '0;

endmodule

// File: tb/tb_match_req_issuer.sv
// Bench for match_req_issuer: directed scenarios plus random jobs, checked
// against a transaction model of issue order, arbitration and best match.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef MATCH_LEN_WIDTH
`define MATCH_LEN_WIDTH 6
`endif

module tb_match_req_issuer;
   localparam int NP = 4;
   localparam int MC = 8;
   localparam int TB = 8;
   localparam int CI = 3;
   localparam int AW = `ADDR_WIDTH;
   localparam int ML = `MATCH_LEN_WIDTH;

   logic              clk = 1'b0;
   logic              rst;
   logic              job_valid;
   logic              job_ready;
   logic [AW-1:0]     job_head_addr;
   logic [CI:0]       job_cand_count;
   logic [MC*AW-1:0]  job_cand_addr;
   logic [NP-1:0]     match_req_valid;
   logic [NP-1:0]     match_req_ready;
   logic [NP*TB-1:0]  match_req_tag;
   logic [NP*AW-1:0]  match_req_head_addr;
   logic [NP*AW-1:0]  match_req_history_addr;
   logic [NP-1:0]     match_resp_valid;
   logic [NP-1:0]     match_resp_ready;
   logic [NP*TB-1:0]  match_resp_tag;
   logic [NP*ML-1:0]  match_resp_match_len;
   logic              result_valid;
   logic              result_ready;
   logic [ML-1:0]     result_match_len;
   logic [CI-1:0]     result_cand_idx;
   logic [AW-1:0]     result_history_addr;

   always #5 clk = ~clk;

   match_req_issuer #(.TAG_BITS(TB), .NUM_PE(NP), .MAX_CAND(MC)) dut (
      .clk(clk), .rst(rst),
      .job_valid(job_valid), .job_ready(job_ready),
      .job_head_addr(job_head_addr),
      .job_cand_count(job_cand_count),
      .job_cand_addr(job_cand_addr),
      .match_req_valid(match_req_valid),
      .match_req_ready(match_req_ready),
      .match_req_tag(match_req_tag),
      .match_req_head_addr(match_req_head_addr),
      .match_req_history_addr(match_req_history_addr),
      .match_resp_valid(match_resp_valid),
      .match_resp_ready(match_resp_ready),
      .match_resp_tag(match_resp_tag),
      .match_resp_match_len(match_resp_match_len),
      .result_valid(result_valid),
      .result_ready(result_ready),
      .result_match_len(result_match_len),
      .result_cand_idx(result_cand_idx),
      .result_history_addr(result_history_addr)
   );

   typedef struct {
      int tag;
      int len;
      int due;
   } rsp_t;

   rsp_t pq [NP][$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   j_cnt, j_head;
   int   j_addr [MC];
   int   j_len  [MC];
   int   j_dly  [MC];
   int   j_tag  [MC];
   int   stall_pe, stall_n, exp_issue;
   bit   rnd_rdy, rst_drain;
   int   m_rr = 0;

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_idle(input string t);
      chk({t, "_job_ready"}, job_ready, 1);
      chk({t, "_req_valid"}, match_req_valid, 0);
      chk({t, "_req_tag"}, match_req_tag, 0);
      chk({t, "_req_head"}, match_req_head_addr, 0);
      chk({t, "_req_hist"}, match_req_history_addr, 0);
      chk({t, "_resp_ready"}, match_resp_ready, 0);
      chk({t, "_res_valid"}, result_valid, 0);
      chk({t, "_res_len"}, result_match_len, 0);
      chk({t, "_res_idx"}, result_cand_idx, 0);
      chk({t, "_res_addr"}, result_history_addr, 0);
   endtask

   // each PE answers its requests in order, each after its own delay
   task automatic drive_resp(input int cyc);
      match_resp_valid     = '0;
      match_resp_tag       = '0;
      match_resp_match_len = '0;
      for (int p = 0; p < NP; p++)
         if (pq[p].size() > 0 && pq[p][0].due <= cyc) begin
            match_resp_valid[p] = 1'b1;
            match_resp_tag[p*TB +: TB] = TB'(pq[p][0].tag);
            match_resp_match_len[p*ML +: ML] = ML'(pq[p][0].len);
         end
   endtask

   task automatic set_job(input int cnt, input int head);
      j_cnt  = cnt;
      j_head = head;
      for (int k = 0; k < MC; k++) begin
         j_addr[k] = int'($urandom_range(1, 65535));
         j_len[k]  = int'($urandom_range(0, 7));
         j_dly[k]  = 1;
         j_tag[k]  = k;
      end
      stall_pe = 0; stall_n = 0; exp_issue = -1;
      rnd_rdy = 1'b0; rst_drain = 1'b0;
   endtask

   task automatic run_job();
      int cyc = 0, acc_cyc = 0, last_iss = 0;
      int cnt = 0, issued = 0, acc = 0;
      int e_len = 0, e_idx = 0, e_addr = 0;
      bit busy = 0, res = 0, done = 0, seen = 0;
      bit iss, col, rfire;
      rsp_t r;
      logic [NP-1:0]    e_rv, e_rr;
      logic [NP*TB-1:0] e_tag;
      logic [NP*AW-1:0] e_head, e_hist;
      logic [MC*AW-1:0] bus;
      // best = longest match over in-range tags, nearest index on ties
      for (int k = 0; k < j_cnt; k++)
         if (j_tag[k] < j_cnt &&
             (!seen || j_len[k] > e_len ||
              (j_len[k] == e_len && j_tag[k] < e_idx))) begin
            seen = 1; e_len = j_len[k]; e_idx = j_tag[k];
         end
      e_addr = (j_cnt == 0) ? 0 : j_addr[e_idx];
      for (int k = 0; k < MC; k++) bus[k*AW +: AW] = AW'(j_addr[k]);
      while (!done && cyc < 300) begin
         @(negedge clk);
         iss = busy && !res && issued < cnt;
         if (!busy) begin
            job_valid = 1'b1;
            job_head_addr = AW'(j_head);
            job_cand_count = (CI+1)'(j_cnt);
            job_cand_addr = bus;
         end else begin
            job_valid = 1'($urandom_range(0, 1));
            job_head_addr = AW'($urandom);
            job_cand_count = (CI+1)'($urandom);
            for (int k = 0; k < MC; k++)
               job_cand_addr[k*AW +: AW] = AW'($urandom);
         end
         match_req_ready = rnd_rdy ? NP'($urandom | $urandom) : '1;
         if (stall_n > 0 && iss && m_rr == stall_pe) begin
            match_req_ready[stall_pe] = 1'b0;
            stall_n--;
         end
         result_ready = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
         drive_resp(cyc);
         #1;
         e_rv = '0; e_tag = '0; e_head = '0; e_hist = '0;
         if (iss) begin
            e_rv[m_rr] = 1'b1;
            e_tag[m_rr*TB +: TB] = TB'(issued);
            e_head[m_rr*AW +: AW] = AW'(j_head);
            e_hist[m_rr*AW +: AW] = AW'(j_addr[issued]);
         end
         chk("req_valid", match_req_valid, e_rv);
         chk("req_tag", match_req_tag, e_tag);
         chk("req_head", match_req_head_addr, e_head);
         chk("req_hist", match_req_history_addr, e_hist);
         rfire = iss && match_req_ready[m_rr];
         if (rfire) begin
            r.tag = j_tag[issued];
            r.len = j_len[issued];
            r.due = cyc + j_dly[issued];
            pq[m_rr].push_back(r);
            drive_resp(cyc);
            #1;
         end
         col  = busy && !res;
         e_rr = col ? (match_resp_valid & (~match_resp_valid + 1'b1)) : '0;
         chk("resp_ready", match_resp_ready, e_rr);
         chk("job_ready", job_ready, !busy);
         chk("res_valid", result_valid, res);
         chk("res_len", result_match_len, res ? e_len : 0);
         chk("res_idx", result_cand_idx, res ? e_idx : 0);
         chk("res_addr", result_history_addr, res ? e_addr : 0);
         if (rst_drain && col && cnt > 0 && issued == cnt) begin
            rst = 1'b1;
            #1;
            chk_idle("rst_drain");
            m_rr = 0;
            job_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < 3; i++) begin
               drive_resp(cyc + 100);
               #1;
               chk("stale_resp_valid", match_resp_valid != '0, 1);
               chk("stale_resp_ready", match_resp_ready, 0);
               chk("stale_job_ready", job_ready, 1);
               @(negedge clk);
            end
            for (int p = 0; p < NP; p++) pq[p].delete();
            drive_resp(0);
            return;
         end
         if (!busy) begin
            busy = 1; cnt = j_cnt; issued = 0; acc = 0;
            res = (j_cnt == 0); acc_cyc = cyc;
         end else if (res) begin
            if (result_ready) done = 1;
         end else begin
            if (rfire) begin
               issued++;
               m_rr = (m_rr + 1) % NP;
               last_iss = cyc;
            end
            if (e_rr != '0) begin
               for (int p = 0; p < NP; p++)
                  if (e_rr[p]) void'(pq[p].pop_front());
               acc++;
               if (acc == cnt) res = 1;
            end
         end
         @(posedge clk);
         cyc++;
      end
      chk("job_done", done, 1);
      if (exp_issue >= 0)
         chk("issue_cycles", last_iss - acc_cyc, exp_issue);
   endtask

   initial begin
      rst = 1'b1;
      job_valid = 1'b0;
      job_head_addr = '0;
      job_cand_count = '0;
      job_cand_addr = '0;
      match_req_ready = '0;
      result_ready = 1'b0;
      drive_resp(0);
      repeat (2) @(negedge clk);
      chk_idle("reset");
      rst = 1'b0;

      // basic four-PE job
      set_job(4, 'h1234);
      j_addr[0] = 100; j_addr[1] = 200; j_addr[2] = 300; j_addr[3] = 400;
      j_len[0] = 3; j_len[1] = 9; j_len[2] = 9; j_len[3] = 2;
      exp_issue = 4;
      run_job();

      // PE1 stalls for five cycles
      set_job(4, 'h0abc);
      j_addr[1] = 200;
      stall_pe = 1; stall_n = 5; exp_issue = 9;
      run_job();

      // PE0 and PE2 respond in the same cycle
      set_job(4, 'h0777);
      j_dly[0] = 2; j_dly[1] = 5; j_dly[2] = 0; j_dly[3] = 5;
      run_job();

      // responses arrive as tags 3,0,2,1
      set_job(4, 'h0888);
      j_len[0] = 5; j_len[1] = 5; j_len[2] = 0; j_len[3] = 5;
      j_dly[0] = 4; j_dly[1] = 5; j_dly[2] = 3; j_dly[3] = 0;
      run_job();

      // empty job
      set_job(0, 'h0999);
      run_job();

      // six candidates wrap the round robin; next job starts on PE2
      set_job(6, 'h0555);
      run_job();
      set_job(3, 'h0666);
      run_job();

      // out-of-range tag is counted but cannot win
      set_job(3, 'h0444);
      j_len[0] = 4; j_len[1] = 7; j_len[2] = 2; j_tag[1] = 6;
      run_job();

      // reset while draining, then a clean job from PE0
      set_job(3, 'h0333);
      for (int k = 0; k < MC; k++) j_dly[k] = 10;
      rst_drain = 1'b1;
      run_job();
      set_job(4, 'h0222);
      j_len[3] = 20;
      exp_issue = 4;
      run_job();

      for (int n = 0; n < 40; n++) begin
         set_job(int'($urandom_range(0, MC)), int'($urandom_range(0, 65535)));
         for (int k = 0; k < MC; k++) j_dly[k] = int'($urandom_range(0, 4));
         rnd_rdy = 1'b1;
         run_job();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/match_req_issuer.md
# match_req_issuer

Job-PE-side initiator for the match PE request/response protocol. It accepts one match job (a head address plus up to MAX_CAND candidate history addresses), issues one match request per candidate across NUM_PE match PEs in round-robin order, and collects the tagged responses. It reduces those responses to the single best candidate and hands that result to the job PE's sequence encoder. Only one job is in flight at a time. The tag carries the candidate index, so responses may return out of order and from any PE.

## Interface
Parameters:
- TAG_BITS, 8: request/response tag width; must be at least $clog2(MAX_CAND).
- NUM_PE, 4: number of attached match PEs.
- MAX_CAND, 8: maximum number of candidates per job; CI = $clog2(MAX_CAND).
- Address and length widths come from `ADDR_WIDTH and `MATCH_LEN_WIDTH in parameters.vh.

Ports (vector buses are PE-major, PE0 in the LSBs):
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- job_valid  in  1  job offered.
- job_ready  out  1  high only in IDLE.
- job_head_addr  in  `ADDR_WIDTH  head address shared by all candidates.
- job_cand_count  in  CI+1  number of candidates, 0..MAX_CAND.
- job_cand_addr  in  MAX_CAND*`ADDR_WIDTH  candidate history addresses; candidate k occupies slice k.
- match_req_valid  out  NUM_PE  per-PE request valid.
- match_req_ready  in  NUM_PE  per-PE request ready.
- match_req_tag  out  NUM_PE*TAG_BITS  zero-extended candidate index.
- match_req_head_addr  out  NUM_PE*`ADDR_WIDTH  head address.
- match_req_history_addr  out  NUM_PE*`ADDR_WIDTH  candidate history address.
- match_resp_valid  in  NUM_PE  per-PE response valid.
- match_resp_ready  out  NUM_PE  per-PE response ready.
- match_resp_tag  in  NUM_PE*TAG_BITS  returned tag.
- match_resp_match_len  in  NUM_PE*`MATCH_LEN_WIDTH  returned match length.
- result_valid  out  1  best-match result valid.
- result_ready  in  1  downstream accept.
- result_match_len  out  `MATCH_LEN_WIDTH  best match length; 0 means no match.
- result_cand_idx  out  CI  index of the winning candidate.
- result_history_addr  out  `ADDR_WIDTH  history address of the winning candidate.

## Operation
State machine: IDLE, ISSUE, DRAIN, RESULT.

- **IDLE**
  - On job_valid && job_ready, latch the head address, count, and candidate addresses.
  - Clear issue_idx, resp_cnt, best_len, best_idx, best_seen.
  - count == 0 → RESULT with len 0, idx 0, addr 0. Otherwise → ISSUE.
- **ISSUE**
  - Exactly one bit of match_req_valid is high, at position rr_ptr.
  - The request carries tag = issue_idx, head = latched head, history = cand_addr[issue_idx]. Unselected request lanes drive 0.
  - Once raised, valid and payload hold until match_req_ready[rr_ptr] is seen; no skipping to another PE.
  - On acceptance: issue_idx += 1; rr_ptr = (rr_ptr + 1) mod NUM_PE.
  - After the request for candidate count−1 is accepted → DRAIN.
- **Response collection (ISSUE and DRAIN)**
  - match_resp_ready is one-hot on the lowest-index PE with match_resp_valid high; all zero otherwise, and all zero in IDLE and RESULT.
  - At most one response is accepted per cycle; resp_cnt += 1.
  - The accepted response (len L, tag t) replaces the best when any of the following holds:
    - best_seen is 0;
    - L > best_len;
    - L == best_len and t < best_idx (a lower index means a nearer candidate).
  - A tag ≥ count is counted but never replaces the best.
- **Exit to RESULT:** in ISSUE or DRAIN, the cycle in which resp_cnt+1 == count → RESULT, from whichever state.
- **RESULT**
  - result_valid is high with best_len, best_idx, and cand_addr[best_idx].
  - Outputs hold stable until result_ready; then → IDLE.
- **rr_ptr** persists across jobs; it is cleared only by reset.

## Timing
- Reset (asynchronous, immediate): state IDLE, rr_ptr 0, all counters and best registers 0.
  - Every output is 0 except job_ready = 1.
  - Reset asserted mid-job abandons the job; responses arriving later from PEs are not accepted until a new job is in ISSUE.
- Job accepted at edge T → first match_req_valid is high in cycle T+1.
- With ready always high, candidate k is issued in cycle T+1+k.
- A response accepted at edge R while in ISSUE or DRAIN that completes the count → result_valid high from R+1.
- Issue and response acceptance can both occur in the same cycle.
- A response may be accepted in the same cycle its request is issued, if a PE answers combinationally.
- Minimum job→result latency for count = n with zero-latency PEs: n+1 cycles.
- result_valid → job_ready: job_ready rises in the cycle after result_ready is seen.

## Test plan
- **Basic four-PE job.** count=4, cand addrs 100/200/300/400, PE response lengths 3/9/9/2, all readies high → requests on PE0..PE3 with tags 0..3 in consecutive cycles. Result len 9, idx 1, addr 200.
- **Backpressure.** match_req_ready[1] held low for 5 cycles → PE1 lane holds tag 1 and addr 200 unchanged for the whole stall. No request appears on PE2 until PE1 accepts; total issue takes count+5 cycles.
- **Simultaneous responses.** PE0 and PE2 valid in the same cycle → only ready[0] is high that cycle; PE2 is accepted the next cycle. resp_cnt reaches count and the result fires.
- **Out-of-order and edge counts.**
  - Responses arrive as tags 3,0,2,1 with lengths 5,5,0,5 → result idx 0.
  - count=0 → result_valid in the cycle after job accept, len 0; no requests issued.
- **Wrap and reset.**
  - MAX_CAND=8, NUM_PE=4, count=6 → issue goes PE0,1,2,3,0,1; the next job starts on PE2.
  - Assert rst during DRAIN → all outputs zero immediately and job_ready=1; the next job completes correctly.
